// File: rtl/sa_ram_rws_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sa_ram_rws_fifo_ctrl
//
// Flow-control wrapper that turns a registered-read-address dual-port RAM
// into a valid/ready FIFO. Producer writes go straight to the RAM write port.
// Reads are issued ahead of demand, and RAM read data lands in a 2-entry
// output buffer. This hides the one-cycle read latency and sustains one
// word per cycle in each direction.
//
// Ports:
//   clk, rstn              clock (rising edge), asynchronous active-low reset
//   wr_pvld/wr_prdy/wr_pd  producer valid/ready/data
//   rd_pvld/rd_prdy/rd_pd  consumer valid/ready/data (head of output buffer)
//   ram_we/ram_wa/ram_di   RAM write port
//   ram_re/ram_ra          RAM read-address capture enable / address
//   ram_dout               RAM read data, valid the cycle after ram_re
//   fifo_cnt               words held in RAM + in flight + output buffer
//   fifo_idle              high when fifo_cnt is zero
// ---------------------------------------------------------------------------
module sa_ram_rws_fifo_ctrl #(
    parameter int DW    = 256,
    parameter int AW    = 7,
    parameter int DEPTH = 128,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic [CW-1:0] fifo_cnt,
    output logic          fifo_idle
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic          inflight_q;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic [DW-1:0] ob_head_q, ob_head_d;
    logic [DW-1:0] ob_tail_q, ob_tail_d;
    logic          wr_prdy_q;

    logic          accept;
    logic          pop;
    logic [2:0]    occupied;

    // Producer side: combinational pass-through to the RAM write port.
    assign wr_prdy = wr_prdy_q;
    assign accept  = wr_pvld & wr_prdy_q;
    assign ram_we  = accept;
    assign ram_wa  = wr_ptr_q;
    assign ram_di  = wr_pd;

    // Consumer side: the buffer head is a register, so rd_pd holds during stalls.
    assign rd_pvld = (ob_cnt_q != 2'd0);
    assign rd_pd   = ob_head_q;
    assign pop     = rd_pvld & rd_prdy;

    // Issue a read only if its data will have a buffer slot when it arrives:
    // slots taken (buffered + in flight) must be below 2 plus any slot freed
    // by a pop in this cycle.
    assign occupied = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
    assign ram_re   = (ram_cnt_q != '0) && (occupied < (3'd2 + {2'b00, pop}));
    assign ram_ra   = rd_ptr_q;

    assign fifo_cnt  = CW'(ram_cnt_q) + CW'(inflight_q) + CW'(ob_cnt_q);
    assign fifo_idle = (fifo_cnt == '0);

    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        ob_cnt_d  = ob_cnt_q;
        ob_head_d = ob_head_q;
        ob_tail_d = ob_tail_q;

        if (accept) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + AW'(1);
        end
        if (ram_re) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + AW'(1);
        end

        case ({accept, ram_re})
            2'b10:   ram_cnt_d = ram_cnt_q + (AW+1)'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - (AW+1)'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase

        // Output buffer: head/tail queue. The in-flight read always has a slot.
        case ({inflight_q, pop})
            2'b10: begin
                if (ob_cnt_q == 2'd0) ob_head_d = ram_dout;
                else                  ob_tail_d = ram_dout;
                ob_cnt_d = ob_cnt_q + 2'd1;
            end
            2'b01: begin
                ob_head_d = ob_tail_q;
                ob_cnt_d  = ob_cnt_q - 2'd1;
            end
            2'b11: begin
                if (ob_cnt_q == 2'd1) begin
                    ob_head_d = ram_dout;
                end else begin
                    ob_head_d = ob_tail_q;
                    ob_tail_d = ram_dout;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
            wr_prdy_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= ram_re;
            ob_cnt_q   <= ob_cnt_d;
            // Based on the next count: a read issued while full does not
            // reopen the write side until the following cycle.
            wr_prdy_q  <= (ram_cnt_d < DEPTH_C);
        end
    end

    // NOTE: buffer data registers, like the RAM array, carry no reset; ob_cnt_q
    // alone marks which entries are meaningful.
    always_ff @(posedge clk) begin
        ob_head_q <= ob_head_d;
        ob_tail_q <= ob_tail_d;
    end

endmodule
